// File: rtl/alux_core.sv
// rtl/alux_core.sv - 64-bit multi-cycle ALU: single-cycle logic/arith, shift-add MUL, restoring DIV/REM.
// Optional divider datapath enabled by defining ALUX_DIV_EN; otherwise opcodes 10/11 return 0 in one cycle.
module alux_core #(
  parameter int WIDTH          = 64,
  parameter int MUL_RADIX_BITS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  inA,
  input  logic [WIDTH-1:0]  inB,
  input  logic [3:0]        opr,
  input  logic              start,
  output logic [WIDTH-1:0]  outAB,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FINISH
  } state_t;

  localparam int         MUL_ITERS = WIDTH / MUL_RADIX_BITS;
  localparam logic [6:0] MUL_LAST  = 7'(MUL_ITERS - 1);
`ifdef ALUX_DIV_EN
  localparam logic [6:0] DIV_LAST  = 7'(WIDTH - 1);
`endif

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [6:0]         r_cnt;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_pp;
  logic [WIDTH-1:0]   w_mul_next;
  logic [5:0]         w_sh;
  logic               w_is_multi;
  logic               w_last;
  logic [6:0]         w_cnt_load;

`ifdef ALUX_DIV_EN
  logic [3:0]         r_op;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  // Restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign w_trial    = {r_acc, r_a[WIDTH-1]} - {1'b0, r_b};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
  assign w_quo_next = {r_a[WIDTH-2:0], w_qbit};
  assign w_is_multi = (opr == 4'd9) || (opr == 4'd10) || (opr == 4'd11);
  assign w_cnt_load = (opr == 4'd9) ? MUL_LAST : DIV_LAST;
`else
  assign w_is_multi = (opr == 4'd9);
  assign w_cnt_load = MUL_LAST;
`endif

  assign w_sh       = inB[5:0];
  assign w_pp       = r_a * {{(WIDTH-MUL_RADIX_BITS){1'b0}}, r_b[MUL_RADIX_BITS-1:0]};
  assign w_mul_next = r_acc + w_pp;
  assign w_last     = (r_cnt == 7'd0);

  always_comb begin
    w_alu = '0;
    case (opr)
      4'd0:    w_alu = inA + inB;
      4'd1:    w_alu = inA - inB;
      4'd2:    w_alu = inA & inB;
      4'd3:    w_alu = inA | inB;
      4'd4:    w_alu = inA ^ inB;
      4'd5:    w_alu = ~inA;
      4'd6:    w_alu = inA << w_sh;
      4'd7:    w_alu = inA >> w_sh;
      4'd8:    w_alu = WIDTH'($signed(inA) >>> w_sh);
      4'd12:   w_alu = (inA < inB) ? inA : inB;
      4'd13:   w_alu = (inA > inB) ? inA : inB;
      4'd14:   w_alu = inA;
      4'd15:   w_alu = inB;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = w_is_multi ? S_BUSY : S_FINISH;
      S_BUSY:   if (w_last) w_next = S_FINISH;
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // outAB is written on the edge entering FINISH so it is valid while done is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      outAB <= '0;
`ifdef ALUX_DIV_EN
      r_op  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= inA;
          r_b   <= inB;
          r_acc <= '0;
          r_cnt <= w_cnt_load;
`ifdef ALUX_DIV_EN
          r_op  <= opr;
`endif
          if (!w_is_multi) outAB <= w_alu;
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 7'd1;
`ifdef ALUX_DIV_EN
          if (r_op != 4'd9) begin
            r_acc <= w_rem_next;
            r_a   <= w_quo_next;
            if (w_last) outAB <= (r_op == 4'd10) ? w_quo_next : w_rem_next;
          end else
`endif
          begin
            r_acc <= w_mul_next;
            r_a   <= r_a << MUL_RADIX_BITS;
            r_b   <= r_b >> MUL_RADIX_BITS;
            if (w_last) outAB <= w_mul_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alux_core.sv
// tb/tb_alux_core.sv - self-checking bench for alux_core with a behavioural reference model.
module tb_alux_core;

  logic        clock;
  logic        reset;
  logic [63:0] inA;
  logic [63:0] inB;
  logic [3:0]  opr;
  logic        start;
  logic [63:0] outAB;
  logic        done;

  int errors = 0;
  int checks = 0;

  alux_core #(.WIDTH(64), .MUL_RADIX_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .inA   (inA),
    .inB   (inB),
    .opr   (opr),
    .start (start),
    .outAB (outAB),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ALUX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int sh;
    sh = int'(b[5:0]);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  begin
        r = a >> sh;
        for (int i = 0; i < sh; i++) r[63-i] = a[63];
      end
      4'd9:  r = a * b;
      4'd10: r = !DIV_EN ? 64'd0 : (b == 0) ? {64{1'b1}} : a / b;
      4'd11: r = !DIV_EN ? 64'd0 : (b == 0) ? a : a % b;
      4'd12: r = (a < b) ? a : b;
      4'd13: r = (a > b) ? a : b;
      4'd14: r = a;
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    if (op == 4'd9) return 17;
    if ((op == 4'd10 || op == 4'd11) && DIV_EN) return 65;
    return 1;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    inA = a; inB = b; opr = op; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    inA = {$urandom, $urandom}; inB = {$urandom, $urandom}; opr = 4'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    res = outAB;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; inA = '0; inB = '0; opr = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (outAB !== 64'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state outAB=%h done=%b want outAB=0 done=0", outAB, done);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_add_sub;
    logic [63:0] r; int lat;
    run_op(4'd0, {64{1'b1}}, 64'd1, r, lat);
    checks++;
    if (r !== 64'd0 || lat !== 1) begin
      errors++; $display("FAIL add_wrap got=%h lat=%0d want=0 lat=1", r, lat);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse done=%b want 0", done);
    end
    run_op(4'd1, 64'd0, 64'd1, r, lat);
    checks++;
    if (r !== {64{1'b1}} || lat !== 1) begin
      errors++; $display("FAIL sub_borrow got=%h lat=%0d want=ffffffffffffffff lat=1", r, lat);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_shifts;
    logic [63:0] r; int lat;
    logic [63:0] exp_v [3];
    exp_v[0] = 64'h0000_0000_0000_0002;
    exp_v[1] = 64'h4000_0000_0000_0000;
    exp_v[2] = 64'hC000_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin
      run_op(4'(6 + i), 64'h8000_0000_0000_0001, 64'h41, r, lat);
      checks++;
      if (r !== exp_v[i] || lat !== 1) begin
        errors++; $display("FAIL shift_op%0d got=%h lat=%0d want=%h lat=1", 6 + i, r, lat, exp_v[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mul;
    int lat;
    inA = 64'h1_0000_0001; inB = 64'h1_0000_0001; opr = 4'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; inA = 64'd7; inB = 64'd9; opr = 4'd0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      start = (lat == 2);
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if (outAB !== 64'h0000_0002_0000_0001 || lat !== 17) begin
      errors++; $display("FAIL mul_basic got=%h lat=%0d want=0000000200000001 lat=17", outAB, lat);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mul_ignored_start done=%b want 0", done);
    end
  endtask

  task automatic test_div;
    logic [63:0] r; int lat;
    logic [63:0] av [4], bv [4]; logic [3:0] ov [4];
    av[0] = 64'd100; bv[0] = 64'd7; ov[0] = 4'd10;
    av[1] = 64'd100; bv[1] = 64'd7; ov[1] = 4'd11;
    av[2] = 64'd9;   bv[2] = 64'd0; ov[2] = 4'd10;
    av[3] = 64'd9;   bv[3] = 64'd0; ov[3] = 4'd11;
    for (int i = 0; i < 4; i++) begin
      run_op(ov[i], av[i], bv[i], r, lat);
      checks++;
      if (r !== model(ov[i], av[i], bv[i]) || lat !== model_lat(ov[i])) begin
        errors++;
        $display("FAIL div_case%0d got=%h lat=%0d want=%h lat=%0d", i, r, lat,
                 model(ov[i], av[i], bv[i]), model_lat(ov[i]));
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_logic;
    logic [63:0] r; int lat;
    logic [3:0]  ops [5];
    logic [63:0] exp_v [5];
    ops[0] = 4'd2;  exp_v[0] = 64'h00F0;
    ops[1] = 4'd3;  exp_v[1] = 64'hFFF0;
    ops[2] = 4'd4;  exp_v[2] = 64'hFF00;
    ops[3] = 4'd12; exp_v[3] = 64'h0FF0;
    ops[4] = 4'd15; exp_v[4] = 64'h0FF0;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], 64'hF0F0, 64'h0FF0, r, lat);
      checks++;
      if (r !== exp_v[i] || lat !== 1) begin
        errors++; $display("FAIL logic_op%0d got=%h lat=%0d want=%h lat=1", ops[i], r, lat, exp_v[i]);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL logic_pulse_op%0d done=%b want 0", ops[i], done);
      end
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (outAB !== 64'h0FF0) begin
      errors++; $display("FAIL hold_outAB got=%h want=0000000000000ff0", outAB);
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b, r; logic [3:0] op; int lat;
    for (int n = 0; n < 40; n++) begin
      a  = {$urandom, $urandom};
      b  = (n % 5 == 0) ? 64'(n) : {$urandom, $urandom};
      op = 4'($urandom);
      run_op(op, a, b, r, lat);
      checks++;
      if (r !== model(op, a, b) || lat !== model_lat(op)) begin
        errors++;
        $display("FAIL random_%0d op=%0d got=%h lat=%0d want=%h lat=%0d", n, op, r, lat,
                 model(op, a, b), model_lat(op));
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_abort;
    bit seen;
    inA = 64'd3; inB = 64'd5; opr = 4'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (outAB !== 64'd0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort outAB=%h done=%b want outAB=0 done=0", outAB, done);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_no_done done pulse seen=1 want 0");
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_shifts;
    test_mul;
    test_div;
    test_logic;
    test_reset_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
